// File: rtl/even_count_run_ctrl.sv
// Start/stop controller for a downstream even counter: synchronized and debounced buttons,
// IDLE/RUN/HOLD state machine, one-shot auto-stop, wrap pulse and saturating wrap tally.
module even_count_run_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       btn_start,
    input  logic       btn_stop,
    input  logic       one_shot,
    input  logic [3:0] count_in,
    output logic       run,
    output logic       paused,
    output logic       wrap_pulse,
    output logic [7:0] wrap_count
);

    localparam logic [3:0] LastCnt  = 4'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0] CountTop = 4'd14;

    typedef enum logic [1:0] {StIdle, StRun, StHold} state_e;

    logic [1:0] btn_raw;
    logic [1:0] press;

    assign btn_raw = {btn_stop, btn_start};

    for (genvar i = 0; i < 2; i++) begin : g_btn
        logic       sync1_q, sync2_q;
        logic       level_q, level_d, level_prev_q;
        logic [3:0] cnt_q, cnt_d;

        always_comb begin
            level_d = level_q;
            cnt_d   = 4'd0;
            if (sync2_q != level_q) begin
                if (cnt_q == LastCnt) begin
                    level_d = ~level_q;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
        end

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                sync1_q      <= 1'b0;
                sync2_q      <= 1'b0;
                level_q      <= 1'b0;
                level_prev_q <= 1'b0;
                cnt_q        <= 4'd0;
            end else begin
                sync1_q      <= btn_raw[i];
                sync2_q      <= sync1_q;
                level_q      <= level_d;
                level_prev_q <= level_q;
                cnt_q        <= cnt_d;
            end
        end

        // Rising edge of the accepted level, seen for the single cycle after it flips.
        assign press[i] = level_q & ~level_prev_q;
    end

    logic       start_ev, stop_ev, at_top;
    state_e     state_q, state_d;
    logic       wc_clear;
    logic       run_q, paused_q, wrap_q, wrap_d;
    logic [7:0] wrap_count_q, wrap_count_d;

    assign start_ev = press[0];
    assign stop_ev  = press[1];
    assign at_top   = (count_in == CountTop);

    always_comb begin
        state_d  = state_q;
        wc_clear = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Stop wins over a simultaneous start.
                if (!stop_ev && start_ev) begin
                    state_d  = StRun;
                    wc_clear = 1'b1;
                end
            end
            StRun: begin
                if (stop_ev) begin
                    state_d = StHold;
                end else if (one_shot && at_top) begin
                    state_d = StIdle;
                end
            end
            StHold: begin
                if (stop_ev) begin
                    state_d  = StIdle;
                    wc_clear = 1'b1;
                end else if (start_ev) begin
                    state_d = StRun;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        wrap_d       = run_q && at_top;
        wrap_count_d = wrap_count_q;
        if (wc_clear) begin
            wrap_count_d = 8'd0;
        end else if (wrap_d && (wrap_count_q != 8'hFF)) begin
            wrap_count_d = wrap_count_q + 8'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            run_q        <= 1'b0;
            paused_q     <= 1'b0;
            wrap_q       <= 1'b0;
            wrap_count_q <= 8'd0;
        end else begin
            state_q      <= state_d;
            run_q        <= (state_d == StRun);
            paused_q     <= (state_d == StHold);
            wrap_q       <= wrap_d;
            wrap_count_q <= wrap_count_d;
        end
    end

    assign run        = run_q;
    assign paused     = paused_q;
    assign wrap_pulse = wrap_q;
    assign wrap_count = wrap_count_q;

endmodule

// File: tb/tb_even_count_run_ctrl.sv
// Bench for even_count_run_ctrl: directed table, corner sequences, and random stimulus
// checked against a history-based reference model.
module tb_even_count_run_ctrl;

    localparam int N    = 4;
    localparam int HMAX = 8192;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       btn_start = 1'b0;
    logic       btn_stop = 1'b0;
    logic       one_shot = 1'b0;
    logic [3:0] count_in;
    logic       run, paused, wrap_pulse;
    logic [7:0] wrap_count;

    logic [3:0] plant;
    logic       ovr_en = 1'b0;
    logic [3:0] ovr_val = 4'd0;

    assign count_in = ovr_en ? ovr_val : plant;

    always #5 clock = ~clock;

    // Downstream even counter driven by the DUT's run enable.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) plant <= 4'd0;
        else if (run) plant <= (plant == 4'd14) ? 4'd0 : plant + 4'd2;
    end

    even_count_run_ctrl #(.DEBOUNCE_CYCLES(N)) dut (
        .clock(clock),
        .reset(reset),
        .btn_start(btn_start),
        .btn_stop(btn_stop),
        .one_shot(one_shot),
        .count_in(count_in),
        .run(run),
        .paused(paused),
        .wrap_pulse(wrap_pulse),
        .wrap_count(wrap_count)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [7:0] act, input int exp);
        tests++;
        if ({24'd0, act} !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset     = 1'b0;
        btn_start = 1'b0;
        btn_stop  = 1'b0;
        one_shot  = 1'b0;
        ovr_en    = 1'b0;
        step(2);
        reset = 1'b1;
    endtask

    // Reference model: a button level is accepted once N consecutive synchronized samples
    // (raw value two edges earlier) all differ from it, counting only edges after the last flip.
    int  m_state;  // 0 idle, 1 run, 2 hold
    bit  m_run, m_paused, m_wp;
    int  m_wc, m_edge;
    bit  hs[HMAX];
    bit  hp[HMAX];
    bit  acc_s, acc_p, ev_s, ev_p;
    int  lf_s, lf_p;

    function automatic bit hist(input bit which, input int idx);
        if (idx < 1 || idx >= HMAX) return 1'b0;
        return which ? hp[idx] : hs[idx];
    endfunction

    task automatic model_reset();
        m_state = 0; m_run = 0; m_paused = 0; m_wp = 0; m_wc = 0; m_edge = 0;
        acc_s = 0; acc_p = 0; ev_s = 0; ev_p = 0; lf_s = 0; lf_p = 0;
    endtask

    task automatic debounce(input bit which, inout bit acc, inout int lf, output bit ev);
        bit all_diff;
        ev = 1'b0;
        if (m_edge - N + 1 > lf) begin
            all_diff = 1'b1;
            for (int x = m_edge - N + 1; x <= m_edge; x++)
                if (hist(which, x - 2) == acc) all_diff = 1'b0;
            if (all_diff) begin
                acc = ~acc;
                lf  = m_edge;
                ev  = acc;
            end
        end
    endtask

    task automatic model_step(input bit bs, input bit bp, input bit os, input int ci);
        m_edge++;
        m_wp = m_run && (ci == 14);
        if (m_wp && m_wc < 255) m_wc++;
        case (m_state)
            0: if (!ev_p && ev_s) begin m_state = 1; m_wc = 0; end
            1: if (ev_p) m_state = 2; else if (os && ci == 14) m_state = 0;
            2: if (ev_p) begin m_state = 0; m_wc = 0; end else if (ev_s) m_state = 1;
            default: m_state = 0;
        endcase
        m_run    = (m_state == 1);
        m_paused = (m_state == 2);
        if (m_edge < HMAX) begin
            hs[m_edge] = bs;
            hp[m_edge] = bp;
        end
        debounce(1'b0, acc_s, lf_s, ev_s);
        debounce(1'b1, acc_p, lf_p, ev_p);
    endtask

    task automatic random_phase(input int cycles, input int ovr_pct);
        int seg_s, seg_p;
        bit cs, cp, co;
        int cc;
        seg_s = 0; seg_p = 0;
        do_reset();
        model_reset();
        for (int c = 0; c < cycles; c++) begin
            check("rnd_run", run, m_run);
            check("rnd_paused", paused, m_paused);
            check("rnd_wrap_pulse", wrap_pulse, m_wp);
            check("rnd_wrap_count", wrap_count, m_wc);
            if (seg_s == 0) begin
                btn_start = 1'($urandom_range(0, 1));
                seg_s     = $urandom_range(1, 10);
            end
            if (seg_p == 0) begin
                btn_stop = ($urandom_range(0, 3) == 0);
                seg_p    = $urandom_range(1, 10);
            end
            seg_s--;
            seg_p--;
            if ($urandom_range(0, 63) == 0) one_shot = ~one_shot;
            ovr_en  = ($urandom_range(0, 99) < ovr_pct);
            ovr_val = 4'($urandom_range(0, 15));
            #1;
            cs = btn_start; cp = btn_stop; co = one_shot; cc = int'(count_in);
            @(posedge clock);
            model_step(cs, cp, co, cc);
            @(negedge clock);
        end
    endtask

    typedef struct {
        bit s;
        bit p;
        int cyc;
        bit er;
        bit ep;
        int ewc;  // -1: not checked
    } vec_t;

    vec_t tbl[12];

    initial begin
        tbl[0]  = '{1, 0, 3, 0, 0, 0};    // 3-cycle glitch
        tbl[1]  = '{0, 0, 10, 0, 0, 0};
        tbl[2]  = '{1, 0, 2, 0, 0, 0};    // 2-cycle glitch
        tbl[3]  = '{0, 0, 10, 0, 0, 0};
        tbl[4]  = '{1, 0, 7, 1, 0, 0};    // clean press
        tbl[5]  = '{0, 0, 10, 1, 0, -1};  // release: no event
        tbl[6]  = '{0, 1, 7, 0, 1, -1};   // stop -> hold
        tbl[7]  = '{0, 0, 7, 0, 1, -1};
        tbl[8]  = '{0, 1, 7, 0, 0, 0};    // stop again -> idle, tally cleared
        tbl[9]  = '{0, 0, 7, 0, 0, 0};
        tbl[10] = '{1, 0, 7, 1, 0, 0};
        tbl[11] = '{0, 0, 7, 1, 0, -1};

        // Reset values, including while reset is held.
        @(negedge clock);
        check("reset_run", run, 0);
        check("reset_paused", paused, 0);
        check("reset_wrap_pulse", wrap_pulse, 0);
        check("reset_wrap_count", wrap_count, 0);

        do_reset();
        foreach (tbl[i]) begin
            btn_start = tbl[i].s;
            btn_stop  = tbl[i].p;
            step(tbl[i].cyc);
            check($sformatf("tbl%0d_run", i), run, tbl[i].er);
            check($sformatf("tbl%0d_paused", i), paused, tbl[i].ep);
            if (tbl[i].ewc >= 0) check($sformatf("tbl%0d_wrap_count", i), wrap_count, tbl[i].ewc);
        end

        // Exact press latency and counter stepping.
        do_reset();
        btn_start = 1'b1;
        step(6);
        check("lat_run_edge6", run, 0);
        step(1);
        check("lat_run_edge7", run, 1);
        check("lat_paused", paused, 0);
        step(1);
        check("lat_count_2", count_in, 2);
        step(1);
        check("lat_count_4", count_in, 4);

        // One-shot: eight counts, one wrap, parked at 0.
        do_reset();
        one_shot  = 1'b1;
        btn_start = 1'b1;
        step(7);
        check("os_run_start", run, 1);
        check("os_count_start", count_in, 0);
        for (int i = 1; i <= 8; i++) begin
            step(1);
            check($sformatf("os_run_%0d", i), run, (i < 8) ? 1 : 0);
            check($sformatf("os_wrap_%0d", i), wrap_pulse, (i == 8) ? 1 : 0);
        end
        check("os_wrap_count", wrap_count, 1);
        check("os_count_parked", count_in, 0);
        step(3);
        check("os_wrap_after", wrap_pulse, 0);
        check("os_run_after", run, 0);
        check("os_count_after", count_in, 0);

        // Simultaneous start/stop in HOLD: stop wins.
        do_reset();
        btn_start = 1'b1; step(7);
        btn_start = 1'b0; step(7);
        btn_stop  = 1'b1; step(7);
        check("both_hold", paused, 1);
        btn_stop  = 1'b0; step(7);
        btn_start = 1'b1;
        btn_stop  = 1'b1;
        step(7);
        check("both_run", run, 0);
        check("both_paused", paused, 0);

        // Reset mid-run with start still held.
        do_reset();
        btn_start = 1'b1;
        step(7);
        step(24);
        check("rst_wc3", wrap_count, 3);
        check("rst_wrap_before", wrap_pulse, 1);
        #2 reset = 1'b0;
        #1;
        check("rst_now_run", run, 0);
        check("rst_now_paused", paused, 0);
        check("rst_now_wrap", wrap_pulse, 0);
        check("rst_now_wc", wrap_count, 0);
        @(negedge clock);
        step(2);
        reset = 1'b1;
        step(6);
        check("rst_rel_edge6", run, 0);
        step(1);
        check("rst_rel_edge7", run, 1);
        check("rst_rel_wc", wrap_count, 0);

        random_phase(3000, 5);
        random_phase(3000, 30);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/even_count_run_ctrl.md
EVEN_COUNT_RUN_CTRL -- requirements
Module: even_count_run_ctrl

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 4, consecutive stable synchronized cycles required to accept a button level change (legal range 2..15).
REQ-002 Port: clock  input  1  rising-edge clock for all state.
REQ-003 Port: reset  input  1  asynchronous, active-low reset.
REQ-004 Port: btn_start  input  1  raw, asynchronous, bouncy start button (1 = pressed).
REQ-005 Port: btn_stop  input  1  raw, asynchronous, bouncy stop button (1 = pressed).
REQ-006 Port: one_shot  input  1  synchronous mode; 1 = auto-stop after one full count cycle.
REQ-007 Port: count_in  input  4  current state of the downstream even counter (0,2,...,14; steps +2 while run=1; 14 wraps to 0).
REQ-008 Port: run  output  1  registered run enable driving the downstream counter.
REQ-009 Port: paused  output  1  registered; 1 while in HOLD.
REQ-010 Port: wrap_pulse  output  1  registered one-cycle pulse per counter wrap.
REQ-011 Port: wrap_count  output  8  registered saturating wrap tally.

Function
REQ-012 Each button SHALL pass through its own 2-flop synchronizer before any other use.
REQ-013 Per button, debounce: synchronized level differing from the accepted level SHALL increment a counter; same level SHALL clear it; when the counter reaches DEBOUNCE_CYCLES-1 and the level still differs, the accepted level SHALL flip and the counter clear.
REQ-014 A press event SHALL be a 0->1 transition of the accepted level; release and bounce shorter than DEBOUNCE_CYCLES cycles SHALL generate no event.
REQ-015 FSM states: IDLE (run=0, paused=0), RUN (run=1, paused=0), HOLD (run=0, paused=1).
REQ-016 IDLE: start event -> RUN; stop event -> stay IDLE.
REQ-017 RUN: stop event -> HOLD; else one_shot=1 and count_in=14 -> IDLE; else stay.
REQ-018 HOLD: start event -> RUN; stop event -> IDLE.
REQ-019 Simultaneous start and stop events in the same cycle SHALL be treated as stop only.
REQ-020 FSM SHALL transition on the clock edge following the edge at which the accepted level flips; run/paused are decoded from registered state (raw start held stable -> run high after edge 3+DEBOUNCE_CYCLES).
REQ-021 wrap_pulse SHALL be 1 for exactly the cycle after any edge sampling run=1 and count_in=14, else 0.
REQ-022 wrap_count SHALL increment with each wrap_pulse, saturate at 255, and clear to 0 on a HOLD->IDLE transition and on IDLE->RUN.
REQ-023 one_shot auto-stop SHALL still produce its wrap_pulse and wrap_count increment.
REQ-024 count_in values outside {0,2,...,14} SHALL never trigger auto-stop or wrap_pulse.

Reset
REQ-025 reset=0 SHALL immediately force: FSM=IDLE, run=0, paused=0, wrap_pulse=0, wrap_count=0, synchronizers=0, accepted levels=0, debounce counters=0.
REQ-026 reset asserted mid-RUN or mid-debounce SHALL discard all progress; after release, a button still held SHALL be re-debounced from scratch and generate a fresh press event.
REQ-027 Outputs SHALL remain at reset values until the first clock edge after reset returns to 1.

Verification (DEBOUNCE_CYCLES=4, period 10)
REQ-028 btn_start held 1 from t=12 after reset release -> run=1 after 7th following edge, paused=0; counter steps 0,2,4,...
REQ-029 btn_start glitches of 1-3 cycles, repeated -> run stays 0, FSM stays IDLE.
REQ-030 RUN, clean btn_stop press -> paused=1, run=0, wrap_count held; second stop press -> IDLE, wrap_count=0.
REQ-031 one_shot=1, start from count 0 -> 8 counts, wrap_pulse once, wrap_count=1, run=0, counter parked at 0.
REQ-032 btn_start and btn_stop raised on the same edge while HOLD -> IDLE (stop wins).
REQ-033 reset pulsed low during RUN with wrap_count=3 while btn_start still held -> all outputs 0 immediately; run returns 1 after 7 edges after release, wrap_count=0.
